// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Serial receiver for the frames produced by uart_tx (same clock domain).
// The frame is a low start bit, 7 or 8 data bits LSB first, an optional
// odd/even parity bit and 1 or 2 high stop bits. The frame format is latched
// when the start bit is first seen, so later changes only affect the next frame.
//
// Ports:
//   clock        system clock, rising edge
//   rst          synchronous active-high reset
//   data_in      serial line, idle high
//   parity_type  00/11 none, 01 odd, 10 even
//   stop_bits    0 one stop bit, 1 two stop bits
//   data_length  0 seven data bits, 1 eight data bits
//   data_out     last received byte (bit 7 is 0 in 7-bit mode)
//   rx_active    high while a frame is being received
//   rx_done      one-cycle strobe; data_out and the error flags update with it
//   parity_error parity mismatch on the last frame
//   frame_error  a stop bit was sampled low on the last frame
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       data_in,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    input  logic       data_length,
    output logic [7:0] data_out,
    output logic       rx_active,
    output logic       rx_done,
    output logic       parity_error,
    output logic       frame_error
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    // position inside a bit period where the line is sampled
    localparam logic [CW-1:0] C_HALF = CW'((CLKS_PER_BIT - 1) / 2);
    // last position of a bit period
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_ZERO = CW'(0);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5,
        S_BREAK  = 3'd6
    } state_t;

    // High when the received data plus parity bit break the selected rule.
    // Only meaningful when parity is enabled.
    function automatic logic parity_fail(input logic [7:0] d, input logic p,
                                         input logic [1:0] ptype);
        logic ones_odd;
        ones_odd    = (^d) ^ p;
        parity_fail = ones_odd ^ (ptype == 2'b01);
    endfunction

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [CW-1:0] w_cnt_adv;
    logic [3:0]    r_bit;
    logic [3:0]    w_bit_next;
    logic [7:0]    r_shift;
    logic          r_par_bit;
    logic          r_ferr;
    logic [1:0]    r_cfg_par;
    logic          r_cfg_stop;
    logic          r_cfg_len;
    logic          w_at_sample;
    logic          w_at_end;
    logic          w_begin;
    logic          w_par_en;
    logic [3:0]    w_last_data;
    logic [3:0]    w_last_stop;
    logic [7:0]    w_data;
    logic          w_active_next;

    // r_cnt is the position inside the current bit for this clock edge.
    // In IDLE/DONE/BREAK it is held at zero, so a start edge is position 0.
    assign w_at_sample = (r_cnt == C_HALF);
    assign w_at_end    = (r_cnt == C_LAST);
    assign w_cnt_adv   = w_at_end ? C_ZERO : (r_cnt + C_ONE);

    assign w_par_en    = (r_cfg_par == 2'b01) || (r_cfg_par == 2'b10);
    assign w_last_data = r_cfg_len  ? 4'd7 : 4'd6;
    assign w_last_stop = r_cfg_stop ? 4'd1 : 4'd0;
    // In 7-bit mode only seven shifts happen, leaving the data in [7:1].
    assign w_data      = r_cfg_len ? r_shift : {1'b0, r_shift[7:1]};

    // The completion cycle reports rx_active=0 even if it also starts the next frame.
    assign w_active_next = (r_state != S_DONE) &&
                           (w_state_next inside {S_START, S_DATA, S_PARITY, S_STOP, S_DONE});

    // Next-state, bit-timing and bit-index logic.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = w_cnt_adv;
        w_bit_next   = r_bit;
        w_begin      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!data_in) begin
                    // Position 0 of a frame; with one clock per bit this is
                    // already the start-bit sample and the bit's last cycle.
                    w_begin      = 1'b1;
                    w_bit_next   = 4'd0;
                    w_state_next = w_at_end ? S_DATA : S_START;
                end else begin
                    w_cnt_next   = C_ZERO;
                    w_state_next = S_IDLE;
                end
            end
            S_START: begin
                if (w_at_sample && data_in) begin
                    w_cnt_next   = C_ZERO;
                    w_state_next = S_IDLE;
                end else if (w_at_end) begin
                    w_state_next = S_DATA;
                end else begin
                    w_state_next = S_START;
                end
            end
            S_DATA: begin
                if (w_at_end && (r_bit == w_last_data)) begin
                    w_bit_next   = 4'd0;
                    w_state_next = w_par_en ? S_PARITY : S_STOP;
                end else if (w_at_end) begin
                    w_bit_next   = r_bit + 4'd1;
                end else begin
                    w_state_next = S_DATA;
                end
            end
            S_PARITY: begin
                if (w_at_end) begin
                    w_state_next = S_STOP;
                end else begin
                    w_state_next = S_PARITY;
                end
            end
            S_STOP: begin
                if (w_at_end && (r_bit == w_last_stop)) begin
                    w_bit_next   = 4'd0;
                    w_state_next = S_DONE;
                end else if (w_at_end) begin
                    w_bit_next   = r_bit + 4'd1;
                end else begin
                    w_state_next = S_STOP;
                end
            end
            S_DONE: begin
                // This cycle is also position 0 of a back-to-back frame.
                if (r_ferr) begin
                    w_cnt_next   = C_ZERO;
                    w_state_next = S_BREAK;
                end else if (!data_in) begin
                    w_begin      = 1'b1;
                    w_bit_next   = 4'd0;
                    w_state_next = w_at_end ? S_DATA : S_START;
                end else begin
                    w_cnt_next   = C_ZERO;
                    w_state_next = S_IDLE;
                end
            end
            S_BREAK: begin
                w_cnt_next = C_ZERO;
                if (data_in) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_BREAK;
                end
            end
            default: begin
                w_cnt_next   = C_ZERO;
                w_bit_next   = 4'd0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= C_ZERO;
            r_bit   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
        end
    end

    // Configuration latch, bit capture and registered outputs.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_shift      <= 8'd0;
            r_par_bit    <= 1'b0;
            r_ferr       <= 1'b0;
            r_cfg_par    <= 2'b00;
            r_cfg_stop   <= 1'b0;
            r_cfg_len    <= 1'b0;
            data_out     <= 8'd0;
            rx_active    <= 1'b0;
            rx_done      <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            rx_active <= w_active_next;
            rx_done   <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                data_out     <= w_data;
                parity_error <= w_par_en && parity_fail(w_data, r_par_bit, r_cfg_par);
                frame_error  <= r_ferr;
            end
            if (w_begin) begin
                r_cfg_par  <= parity_type;
                r_cfg_stop <= stop_bits;
                r_cfg_len  <= data_length;
                r_ferr     <= 1'b0;
            end
            if ((r_state == S_DATA) && w_at_sample) begin
                r_shift <= {data_in, r_shift[7:1]};
            end
            if ((r_state == S_PARITY) && w_at_sample) begin
                r_par_bit <= data_in;
            end
            // Every stop bit is sampled; any low one marks the frame.
            if ((r_state == S_STOP) && w_at_sample && !data_in) begin
                r_ferr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       line1, line4;
    logic [1:0] ptype;
    logic       sbits, dlen;
    logic [7:0] dout1, dout4;
    logic       act1, act4, done1, done4, perr1, perr4, ferr1, ferr4;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(1)) dut1 (
        .clock(clk), .rst(rst), .data_in(line1), .parity_type(ptype),
        .stop_bits(sbits), .data_length(dlen), .data_out(dout1),
        .rx_active(act1), .rx_done(done1), .parity_error(perr1), .frame_error(ferr1)
    );

    uart_rx #(.CLKS_PER_BIT(4)) dut4 (
        .clock(clk), .rst(rst), .data_in(line4), .parity_type(ptype),
        .stop_bits(sbits), .data_length(dlen), .data_out(dout4),
        .rx_active(act4), .rx_done(done4), .parity_error(perr4), .frame_error(ferr4)
    );

    int errors = 0;
    int checks = 0;
    int sel_cpb = 1;

    logic [7:0] obs_data;
    logic       obs_act, obs_done, obs_perr, obs_ferr;

    // expectation for the completion cycle of the frame just sent
    logic       pend = 1'b0;
    logic [7:0] pend_data;
    logic       pend_perr, pend_ferr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input logic v);
        if (sel_cpb == 4) begin
            line4 = v;
            line1 = 1'b1;
        end else begin
            line1 = v;
            line4 = 1'b1;
        end
    endtask

    task automatic sample();
        if (sel_cpb == 4) begin
            obs_data = dout4; obs_act = act4; obs_done = done4; obs_perr = perr4; obs_ferr = ferr4;
        end else begin
            obs_data = dout1; obs_act = act1; obs_done = done1; obs_perr = perr1; obs_ferr = ferr1;
        end
    endtask

    // one clock edge; outputs are looked at 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
        sample();
        if (pend) begin
            check("rx_done_pulse", 32'(obs_done), 32'(1'b1));
            check("data_out", 32'(obs_data), 32'(pend_data));
            check("parity_error", 32'(obs_perr), 32'(pend_perr));
            check("frame_error", 32'(obs_ferr), 32'(pend_ferr));
            check("rx_active_at_done", 32'(obs_act), 32'(1'b0));
            pend = 1'b0;
        end else begin
            check("no_rx_done", 32'(obs_done), 32'(1'b0));
        end
    endtask

    task automatic idle(input int n);
        set_line(1'b1);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reference model: build the frame as a bit list, drive it, and set the
    // expected result for the cycle that follows the frame.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic sb,
                              input logic dl, input logic bad_par, input logic bad_stop,
                              input logic chained);
        logic       bits[$];
        logic [7:0] exp_d;
        logic       pbit;
        logic       par_en;
        int         nd, cpb, act_bad;
        cpb     = sel_cpb;
        nd      = dl ? 8 : 7;
        exp_d   = dl ? d : {1'b0, d[6:0]};
        par_en  = (pt == 2'b01) || (pt == 2'b10);
        act_bad = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) bits.push_back(exp_d[i]);
        if (par_en) begin
            // odd: total ones odd; even: total ones even
            pbit = (pt == 2'b01) ? ~(^exp_d) : (^exp_d);
            bits.push_back(pbit ^ bad_par);
        end
        bits.push_back(~bad_stop);
        if (sb) bits.push_back(1'b1);
        for (int k = 0; k < bits.size() * cpb; k++) begin
            set_line(bits[k / cpb]);
            if (k == 0) begin
                ptype = pt; sbits = sb; dlen = dl;
            end else begin
                ptype = 2'($urandom); sbits = 1'($urandom); dlen = 1'($urandom);
            end
            tick();
            if (!(k == 0 && chained) && (obs_act !== 1'b1)) act_bad++;
        end
        check("rx_active_in_frame", 32'(act_bad), 32'(0));
        pend      = 1'b1;
        pend_data = exp_d;
        pend_perr = par_en && bad_par;
        pend_ferr = bad_stop;
    endtask

    task automatic check_all_zero(input string tag);
        sample();
        check({tag, "_data_out"}, 32'(obs_data), 32'(8'd0));
        check({tag, "_rx_active"}, 32'(obs_act), 32'(1'b0));
        check({tag, "_rx_done"}, 32'(obs_done), 32'(1'b0));
        check({tag, "_parity_error"}, 32'(obs_perr), 32'(1'b0));
        check({tag, "_frame_error"}, 32'(obs_ferr), 32'(1'b0));
    endtask

    initial begin
        logic [7:0] rd, partial;
        logic [1:0] rpt;
        logic       rsb, rdl, rbp, rbs, rch, rbp2, rbs2;
        int         bad_act;

        rst = 1'b1; line1 = 1'b1; line4 = 1'b1; ptype = 2'b00; sbits = 1'b0; dlen = 1'b1;
        tick(); tick();
        sel_cpb = 1; check_all_zero("reset1");
        sel_cpb = 4; check_all_zero("reset4");
        rst = 1'b0;
        sel_cpb = 1;
        idle(2);

        // 7-bit odd parity, 0x16
        send_frame(8'h16, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        // 8-bit even parity two stops, 0x96
        send_frame(8'h96, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        // odd parity with wrong parity bit, then a clean frame
        send_frame(8'h96, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        send_frame(8'h5B, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);

        // low stop bit followed by a 5-cycle low hold
        send_frame(8'hC3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        set_line(1'b0);
        bad_act = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (obs_act !== 1'b0) bad_act++;
        end
        check("no_active_in_break", 32'(bad_act), 32'(0));
        idle(1);
        send_frame(8'h81, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);

        // back-to-back frames, one clock per bit
        send_frame(8'h3A, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h7E, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // four clocks per bit: glitch, then a full frame
        sel_cpb = 4;
        idle(2);
        set_line(1'b0);
        tick();
        check("glitch_active_c0", 32'(obs_act), 32'(1'b1));
        set_line(1'b1);
        tick();
        tick();
        check("glitch_active_c2", 32'(obs_act), 32'(1'b0));
        idle(8);
        send_frame(8'hA5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        send_frame(8'h96, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'h2D, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // reset during data bit 3
        sel_cpb = 1;
        partial = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            set_line((k == 0) ? 1'b0 : partial[k - 1]);
            tick();
        end
        set_line(partial[3]);
        rst = 1'b1;
        tick();
        check_all_zero("mid_reset");
        rst = 1'b0;
        idle(2);
        send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);

        // random frames on both receivers
        for (int i = 0; i < 40; i++) begin
            sel_cpb = ($urandom_range(0, 1) == 1) ? 4 : 1;
            idle(1);
            rd  = 8'($urandom_range(0, 255));
            rpt = 2'($urandom);
            rsb = 1'($urandom);
            rdl = 1'($urandom);
            rbp = ($urandom_range(0, 3) == 0);
            rbs = ($urandom_range(0, 4) == 0);
            rch = ($urandom_range(0, 2) == 0) && !rbs;
            send_frame(rd, rpt, rsb, rdl, rbp, rbs, 1'b0);
            if (rch) begin
                rbp2 = ($urandom_range(0, 3) == 0);
                rbs2 = ($urandom_range(0, 4) == 0);
                send_frame(8'($urandom_range(0, 255)), 2'($urandom), 1'($urandom),
                           1'($urandom), rbp2, rbs2, 1'b1);
                idle(rbs2 ? 2 : 1);
            end else begin
                idle(rbs ? 2 : 1);
            end
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that consumes the `data_out` line of `uart_tx` and recovers the parallel byte.
- Frame format is runtime-selectable, with the same configuration inputs as `uart_tx`.
- Checks parity and stop bits, then presents the byte with a one-cycle done strobe.
- Sits directly downstream of `uart_tx`, in the same clock domain.

Parameters:
- CLKS_PER_BIT, 1, clock cycles per serial bit. Must be ≥1. Default matches `uart_tx` (one bit per clock).

Ports:
- clock  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  1  serial line; idle high. Synchronous to clock, so no synchronizer is fitted.
- parity_type  input  2  00 = none, 01 = odd, 10 = even, 11 = none.
- stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
- data_length  input  1  0 = 7 data bits, 1 = 8 data bits.
- data_out  output  8  received data, LSB first on the line; bit 7 = 0 in 7-bit mode.
- rx_active  output  1  high while a frame is being received.
- rx_done  output  1  one-cycle pulse; data_out and error flags are updated in the same cycle.
- parity_error  output  1  parity mismatch on the last frame.
- frame_error  output  1  a stop bit sampled low on the last frame.

Behaviour:
- Reset (rst=1 at a rising edge) overrides everything, including mid-frame. On reset:
  - data_out=0, rx_active=0, rx_done=0, parity_error=0, frame_error=0.
  - State goes to IDLE; counters cleared.
- Timing:
  - HALF = (CLKS_PER_BIT-1)/2, integer division.
  - Cycle 0 is the first cycle data_in is seen low in IDLE.
  - Bit k of the frame (k=0 is the start bit) is sampled at cycle k*CLKS_PER_BIT+HALF.
  - With CLKS_PER_BIT=1, every bit is sampled in its own cycle and the start bit is sampled at cycle 0.
- Configuration: parity_type, stop_bits and data_length are latched at cycle 0. Changes mid-frame are ignored.
- Frame length in bits: L = 1 + (7 or 8) + (1 if parity enabled) + (1 or 2).
- States:
  - IDLE: rx_active=0. A low on data_in goes to START and sets rx_active=1 from cycle 0. The START decision is taken at cycle HALF (cycle 0 when CLKS_PER_BIT=1).
  - START: at the sample point:
    - data_in=1 is a false start: return to IDLE, rx_active drops next cycle, no rx_done.
    - data_in=0 goes to DATA.
  - DATA: 7 or 8 samples, shifted in LSB first.
  - PARITY: entered only if parity is enabled; one sample.
    - Odd: the ones-count of data plus parity bit must be odd.
    - Even: the ones-count must be even.
  - STOP: 1 or 2 samples. Any stop sample of 0 sets the pending frame error.
    - Both stop bits are always sampled; reception never aborts early.
  - Completion, the cycle after the last stop sample:
    - rx_done=1 for exactly one cycle.
    - data_out, parity_error and frame_error load the new values and hold them until the next rx_done.
    - rx_active=0 in this cycle.
  - From completion:
    - If the frame had no frame error, go to IDLE.
    - If it had a frame error, go to BREAK_WAIT.
  - BREAK_WAIT: stay until data_in=1 is seen, then go to IDLE. A start bit cannot be detected while in BREAK_WAIT.
- Back-to-back frames: a start bit immediately after the last stop bit must be detected.
  - At CLKS_PER_BIT=1, the start-bit low appears in the completion cycle. It is detected in that cycle; the completion cycle then doubles as cycle 0 of the next frame, and rx_active goes high again in the cycle after rx_done.
  - No dead cycle is allowed.
- Counters: bit-timing counter is $clog2(CLKS_PER_BIT)+1 bits wide, bit index counter is 4 bits. Neither may wrap within a frame.

Test Plan:
- CLKS_PER_BIT=1, 7-bit, odd parity, 1 stop; line sends 0,0,1,1,0,1,0,0,0,1 from cycle 0 -> rx_done at cycle 10, data_out=8'h16, parity_error=0, frame_error=0; rx_active high cycles 0–9.
- 8-bit, even parity, 2 stop; send 8'h96 with parity bit 0 -> rx_done at cycle 12, data_out=8'h96, both error flags 0.
- 8-bit, odd parity; send 8'h96 with parity bit 0 (should be 1) -> rx_done with parity_error=1, data_out=8'h96. Next clean frame clears parity_error.
- 8-bit, no parity, 1 stop; stop bit driven 0, then line held low 5 cycles -> frame_error=1 with rx_done at cycle 10; no rx_active during the low hold; line high one cycle, then a new start is received normally.
- CLKS_PER_BIT=4: 1-cycle low glitch -> no rx_done, rx_active drops after cycle 1. Full frame 8'hA5, no parity -> data_out=8'hA5, rx_done at cycle 40.
- Reset mid-frame: rst=1 during data bit 3 -> next cycle all outputs 0, state IDLE; the subsequent frame 8'h3C is received correctly.
